// File: rtl/prog_store.sv
// prog_store: double-buffered instruction store feeding the PWM execution stage.
//
// The execution stage reads the active bank combinationally at pc_i. A new
// program streams in (valid/ready) into the shadow bank; once all DEPTH words
// are in, the store waits in StPending and swaps banks on the next start_i, so
// the execution stage never sees a partially loaded program.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         PWM period start strobe
//   pc_i            read address from the execution-stage program counter
//   instr_o         active-bank word at pc_i (combinational)
//   load_valid_i    load word valid
//   load_ready_o    store accepts a load word this cycle
//   load_data_i     load word
//   load_abort_i    discard partial or pending load
//   pending_o       shadow bank full, waiting for start_i
//   swap_o          one-cycle pulse in the cycle after a bank swap
//   bank_o          index of the active bank
module prog_store #(
  parameter int INSTR_WIDTH = 6,
  parameter int PC_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [INSTR_WIDTH-1:0] load_data_i,
  input  logic                   load_abort_i,
  output logic                   pending_o,
  output logic                   swap_o,
  output logic                   bank_o
);

  localparam int DEPTH = 2 ** PC_WIDTH;

  typedef enum logic {
    StFill    = 1'b0,
    StPending = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic                    bank_q, bank_d;
  logic                    swap_q, swap_d;
  logic [INSTR_WIDTH-1:0]  mem_q [2][DEPTH];
  logic [INSTR_WIDTH-1:0]  mem_d [2][DEPTH];

  logic                    shadow_s;
  logic                    last_s;

  assign shadow_s = ~bank_q;
  assign last_s   = (wr_ptr_q == PC_WIDTH'(DEPTH - 1));

  // Reads always come from the active bank; loading only touches the shadow.
  assign instr_o      = mem_q[bank_q][pc_i];
  assign load_ready_o = (state_q == StFill) & ~load_abort_i;
  assign pending_o    = (state_q == StPending);
  assign swap_o       = swap_q;
  assign bank_o       = bank_q;

  // Next-state: load sequencing, shadow writes and bank swap decision.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    bank_d   = bank_q;
    swap_d   = 1'b0;
    mem_d    = mem_q;
    case (state_q)
      StFill: begin
        // start_i is ignored here: a final word arriving with start_i
        // only reaches StPending and waits for the next period.
        if (load_abort_i) begin
          wr_ptr_d = {PC_WIDTH{1'b0}};
        end else if (load_valid_i) begin
          mem_d[shadow_s][wr_ptr_q] = load_data_i;
          if (last_s) begin
            wr_ptr_d = {PC_WIDTH{1'b0}};
            state_d  = StPending;
          end else begin
            wr_ptr_d = wr_ptr_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      StPending: begin
        // Abort takes priority over a coincident start_i.
        if (load_abort_i) begin
          state_d  = StFill;
          wr_ptr_d = {PC_WIDTH{1'b0}};
        end else if (start_i) begin
          state_d  = StFill;
          wr_ptr_d = {PC_WIDTH{1'b0}};
          bank_d   = ~bank_q;
          swap_d   = 1'b1;
        end else begin
          state_d  = StPending;
        end
      end
      default: begin
        state_d  = StFill;
        wr_ptr_d = {PC_WIDTH{1'b0}};
      end
    endcase
  end

  // State, pointer, bank select, swap pulse and both banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      wr_ptr_q <= {PC_WIDTH{1'b0}};
      bank_q   <= 1'b0;
      swap_q   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= {INSTR_WIDTH{1'b0}};
        end
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      bank_q   <= bank_d;
      swap_q   <= swap_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_prog_store.sv
// tb_prog_store: self-checking bench for prog_store. Read checks are queued as
// expected records when pc_i is driven and popped/compared at the falling edge.
module tb_prog_store;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] pc_i = 4'd0;
  logic [5:0] instr_o;
  logic       load_valid_i = 1'b0;
  logic       load_ready_o;
  logic [5:0] load_data_i = 6'd0;
  logic       load_abort_i = 1'b0;
  logic       pending_o;
  logic       swap_o;
  logic       bank_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [3:0] pc;
    logic [5:0] instr;
    logic       bank;
    logic       pending;
    logic       ready;
    logic       swap;
  } vec_t;

  vec_t       exp_q[$];
  vec_t       rst_tbl[16];
  logic [5:0] exp_active[16];
  logic [5:0] words[16];

  prog_store #(.INSTR_WIDTH(6), .PC_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .load_data_i (load_data_i),
    .load_abort_i(load_abort_i),
    .pending_o   (pending_o),
    .swap_o      (swap_o),
    .bank_o      (bank_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive pc_i, queue the expectation, compare at the falling edge, then step.
  task automatic apply_read(input string nm, input logic [3:0] pc, input logic [5:0] ei,
                            input logic eb, input logic ep, input logic er, input logic es);
    vec_t v, g;
    v.name = nm; v.pc = pc; v.instr = ei; v.bank = eb;
    v.pending = ep; v.ready = er; v.swap = es;
    pc_i = pc;
    exp_q.push_back(v);
    @(negedge clk);
    g = exp_q.pop_front();
    chk($sformatf("%s.instr@%0d", g.name, g.pc), {2'b00, instr_o}, {2'b00, g.instr});
    chk($sformatf("%s.bank", g.name), {7'd0, bank_o}, {7'd0, g.bank});
    chk($sformatf("%s.pending", g.name), {7'd0, pending_o}, {7'd0, g.pending});
    chk($sformatf("%s.ready", g.name), {7'd0, load_ready_o}, {7'd0, g.ready});
    chk($sformatf("%s.swap", g.name), {7'd0, swap_o}, {7'd0, g.swap});
    tick();
  endtask

  // Sweep every active entry against the bench's own copy of the program.
  task automatic check_all(input string nm, input logic eb);
    for (int i = 0; i < 16; i++) begin
      apply_read(nm, 4'(i), exp_active[i], eb, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Stream n words; optional random idle gaps; optional start_i on the last accept.
  task automatic stream(input string nm, input int n, input bit gaps, input bit start_last);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      load_valid_i = 1'b1;
      load_data_i  = words[i];
      start_i      = start_last && (i == n - 1);
      @(negedge clk);
      chk($sformatf("%s.ready_w%0d", nm, i), {7'd0, load_ready_o}, 8'd1);
      tick();
      load_valid_i = 1'b0;
      start_i      = 1'b0;
    end
  endtask

  // Pulse start_i for one period and check the swap happens on that edge.
  task automatic do_swap(input string nm, input logic old_bank, input logic [5:0] new3);
    start_i = 1'b1;
    apply_read({nm, "_pre"}, 4'd3, exp_active[3], old_bank, 1'b1, 1'b0, 1'b0);
    start_i = 1'b0;
    apply_read({nm, "_post"}, 4'd3, new3, ~old_bank, 1'b0, 1'b1, 1'b1);
    apply_read({nm, "_after"}, 4'd3, new3, ~old_bank, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rst_tbl[i] = '{name: "rst_sweep", pc: 4'(i), instr: 6'h00, bank: 1'b0,
                     pending: 1'b0, ready: 1'b1, swap: 1'b0};
      exp_active[i] = 6'h00;
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, table driven
    foreach (rst_tbl[i]) begin
      apply_read(rst_tbl[i].name, rst_tbl[i].pc, rst_tbl[i].instr, rst_tbl[i].bank,
                 rst_tbl[i].pending, rst_tbl[i].ready, rst_tbl[i].swap);
    end

    // 2: full load 01..10, junk valid while pending, then swap
    for (int i = 0; i < 16; i++) words[i] = 6'(i + 1);
    stream("load1", 16, 1'b0, 1'b0);
    apply_read("pend1", 4'd3, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid_i = 1'b1;
    load_data_i  = 6'h3F;
    apply_read("pend1_junk", 4'd3, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    load_valid_i = 1'b0;
    do_swap("swap1", 1'b0, 6'h04);
    for (int i = 0; i < 16; i++) exp_active[i] = words[i];
    check_all("act1", 1'b1);

    // 3: last word accepted on the start_i edge -> no swap until next start_i
    for (int i = 0; i < 16; i++) words[i] = 6'(8'h20 + i);
    stream("load2", 16, 1'b0, 1'b1);
    apply_read("same_edge", 4'd3, 6'h04, 1'b1, 1'b1, 1'b0, 1'b0);
    do_swap("swap2", 1'b1, 6'h23);
    for (int i = 0; i < 16; i++) exp_active[i] = words[i];
    check_all("act2", 1'b0);

    // 4: 7 words, abort (presented word discarded), then full 2A load
    for (int i = 0; i < 16; i++) words[i] = 6'(8'h11 + i);
    stream("part", 7, 1'b0, 1'b0);
    load_abort_i = 1'b1;
    load_valid_i = 1'b1;
    load_data_i  = 6'h3F;
    apply_read("abort_fill", 4'd3, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    load_abort_i = 1'b0;
    load_valid_i = 1'b0;
    for (int i = 0; i < 16; i++) words[i] = 6'h2A;
    stream("load3", 16, 1'b0, 1'b0);
    do_swap("swap3", 1'b0, 6'h2A);
    for (int i = 0; i < 16; i++) exp_active[i] = 6'h2A;
    check_all("act3", 1'b1);

    // 5: abort and start together while pending -> abort wins
    for (int i = 0; i < 16; i++) words[i] = 6'(8'h30 + i);
    stream("load4", 16, 1'b0, 1'b0);
    start_i      = 1'b1;
    load_abort_i = 1'b1;
    apply_read("ab_st_pre", 4'd5, 6'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
    start_i      = 1'b0;
    load_abort_i = 1'b0;
    apply_read("ab_st_post", 4'd5, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
    start_i = 1'b1;
    apply_read("fill_start", 4'd5, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
    start_i = 1'b0;
    apply_read("fill_start_after", 4'd5, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0);

    // 6: random gaps, reset mid-stream, then a clean full load
    for (int i = 0; i < 16; i++) words[i] = 6'($urandom_range(1, 63));
    stream("part_rst", 9, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_active[i] = 6'h00;
    foreach (rst_tbl[i]) begin
      apply_read("rst2_sweep", rst_tbl[i].pc, rst_tbl[i].instr, rst_tbl[i].bank,
                 rst_tbl[i].pending, rst_tbl[i].ready, rst_tbl[i].swap);
    end
    for (int i = 0; i < 16; i++) words[i] = 6'($urandom_range(1, 63));
    stream("load5", 16, 1'b1, 1'b0);
    do_swap("swap5", 1'b0, words[3]);
    for (int i = 0; i < 16; i++) exp_active[i] = words[i];
    check_all("act5", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
